// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider (DIV/DIVU) with its sequencing FSM.
// Result is packed {remainder, quotient} and held in END until the requester drops start_i.
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  busy_o,
    output logic [1:0]            state_o
);
    // Handshake: start_i is a level request held with stable operands until ready_o
    // is seen; ready_o/result_o stay valid until start_i is sampled low, then clear.
    localparam int CNT_W = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {
        S_FREE    = 2'd0,
        S_DIVZERO = 2'd1,
        S_ON      = 2'd2,
        S_END     = 2'd3
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W:0]     rem_r;
    logic [DATA_W-1:0]   quo_r;
    logic [DATA_W-1:0]   b_mag;
    logic                sa;
    logic                sb;
    logic                sgn;

    logic [DATA_W-1:0]   a_in_mag;
    logic [DATA_W-1:0]   b_in_mag;
    logic [DATA_W:0]     trial;
    logic [DATA_W-1:0]   quo_fix;
    logic [DATA_W-1:0]   rem_fix;

    always_comb begin
        a_in_mag = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
        b_in_mag = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
        trial    = {rem_r[DATA_W-1:0], quo_r[DATA_W-1]} - {1'b0, b_mag};
        // Remainder follows the dividend's sign; 0x80000000/-1 wraps naturally.
        quo_fix  = (sgn && (sa ^ sb)) ? -quo_r : quo_r;
        rem_fix  = (sgn && sa) ? -rem_r[DATA_W-1:0] : rem_r[DATA_W-1:0];
    end

    assign busy_o  = (state == S_ON) || (state == S_DIVZERO);
    assign state_o = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FREE;
            cnt      <= '0;
            result_o <= '0;
            ready_o  <= 1'b0;
            rem_r    <= '0;
            quo_r    <= '0;
            b_mag    <= '0;
            sa       <= 1'b0;
            sb       <= 1'b0;
            sgn      <= 1'b0;
        end else if (annul_i && state != S_FREE) begin
            state    <= S_FREE;
            cnt      <= '0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                S_FREE: begin
                    if (start_i && !annul_i) begin
                        if (opdata2_i == '0) begin
                            state <= S_DIVZERO;
                        end else begin
                            sa    <= signed_div_i & opdata1_i[DATA_W-1];
                            sb    <= signed_div_i & opdata2_i[DATA_W-1];
                            sgn   <= signed_div_i;
                            rem_r <= '0;
                            quo_r <= a_in_mag;
                            b_mag <= b_in_mag;
                            cnt   <= '0;
                            state <= S_ON;
                        end
                    end
                end
                S_DIVZERO: begin
                    result_o <= '0;
                    ready_o  <= 1'b1;
                    state    <= S_END;
                end
                S_ON: begin
                    if (cnt != CNT_W'(DATA_W)) begin
                        if (!trial[DATA_W]) begin
                            rem_r <= trial;
                            quo_r <= {quo_r[DATA_W-2:0], 1'b1};
                        end else begin
                            rem_r <= {rem_r[DATA_W-1:0], quo_r[DATA_W-1]};
                            quo_r <= {quo_r[DATA_W-2:0], 1'b0};
                        end
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        result_o <= {rem_fix, quo_fix};
                        ready_o  <= 1'b1;
                        state    <= S_END;
                    end
                end
                S_END: begin
                    if (!start_i) begin
                        state    <= S_FREE;
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end
                end
                default: state <= S_FREE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed/unsigned results, divide-by-zero,
// annul, reset mid-operation and operand stability after the latch edge.
module tb_div_unit;
    localparam int DATA_W = 32;

    logic                clk;
    logic                rst;
    logic                signed_div_i;
    logic [DATA_W-1:0]   opdata1_i;
    logic [DATA_W-1:0]   opdata2_i;
    logic                start_i;
    logic                annul_i;
    logic [2*DATA_W-1:0] result_o;
    logic                ready_o;
    logic                busy_o;
    logic [1:0]          state_o;

    int total = 0;
    int bad   = 0;

    localparam logic [1:0] ST_FREE = 2'd0;
    localparam logic [1:0] ST_DZ   = 2'd1;
    localparam logic [1:0] ST_ON   = 2'd2;
    localparam logic [1:0] ST_END  = 2'd3;

    div_unit #(.DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
        .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
        .start_i(start_i), .annul_i(annul_i),
        .result_o(result_o), .ready_o(ready_o), .busy_o(busy_o), .state_o(state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ready"}, 64'(ready_o), 64'd0);
        check({tag, "_result"}, result_o, 64'd0);
        check({tag, "_busy"}, 64'(busy_o), 64'd0);
        check({tag, "_state"}, 64'(state_o), 64'(ST_FREE));
    endtask

    // Issue a divide and check exact latency; scramble operands after latch if asked.
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp, input logic scramble);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        step();
        check({tag, "_busy_on"}, 64'(busy_o), 64'd1);
        if (scramble) begin
            opdata1_i    = 32'h0BAD_F00D;
            opdata2_i    = 32'h0000_0005;
            signed_div_i = ~sgn;
        end
        repeat (32) step();
        check({tag, "_not_ready_e33"}, 64'(ready_o), 64'd0);
        step();
        check({tag, "_ready_e34"}, 64'(ready_o), 64'd1);
        check({tag, "_result"}, result_o, exp);
        check({tag, "_state_end"}, 64'(state_o), 64'(ST_END));
    endtask

    task automatic drop_start(input string tag);
        step();
        check({tag, "_held"}, 64'(ready_o), 64'd1);
        start_i = 1'b0;
        step();
        check_idle({tag, "_drop"});
    endtask

    initial begin
        rst = 1'b1; signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
        start_i = 1'b0; annul_i = 1'b0;
        step();
        step();
        check_idle("reset");
        rst = 1'b0;
        step();

        run_div("u100_7", 1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 1'b0);
        drop_start("u100_7");

        run_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'h2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
        drop_start("s_m7_2");

        run_div("u_m7_2", 1'b0, 32'hFFFF_FFF9, 32'h2, {32'h1, 32'h7FFF_FFFC}, 1'b1);
        drop_start("u_m7_2");

        // Divide by zero
        signed_div_i = 1'b0; opdata1_i = 32'h1234_5678; opdata2_i = '0; start_i = 1'b1;
        step();
        check("dz_busy_e1", 64'(busy_o), 64'd1);
        check("dz_state_e1", 64'(state_o), 64'(ST_DZ));
        check("dz_ready_e1", 64'(ready_o), 64'd0);
        step();
        check("dz_ready_e2", 64'(ready_o), 64'd1);
        check("dz_busy_e2", 64'(busy_o), 64'd0);
        check("dz_result", result_o, 64'd0);
        start_i = 1'b0;
        step();
        check_idle("dz_drop");

        // Annul when cnt==10 (cnt is 10 after edge 11)
        signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
        repeat (11) step();
        check("annul_pre_state", 64'(state_o), 64'(ST_ON));
        annul_i = 1'b1; start_i = 1'b0;
        step();
        check_idle("annul");
        annul_i = 1'b0;
        step();
        check_idle("annul_stay");

        // Annul wins over simultaneous start in FREE
        annul_i = 1'b1; start_i = 1'b1; opdata1_i = 32'd9; opdata2_i = 32'd3;
        step();
        check_idle("annul_blocks");
        annul_i = 1'b0; start_i = 1'b0;
        step();

        run_div("u9_3", 1'b0, 32'd9, 32'd3, {32'h0, 32'h3}, 1'b0);
        drop_start("u9_3");

        run_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 1'b0);
        drop_start("s_ovf");

        run_div("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'h1, {32'h0, 32'hFFFF_FFFF}, 1'b1);
        drop_start("u_max_1");

        // Reset mid-operation at cnt==20
        signed_div_i = 1'b1; opdata1_i = 32'd77; opdata2_i = 32'd5; start_i = 1'b1;
        repeat (21) step();
        check("rst_mid_pre_busy", 64'(busy_o), 64'd1);
        rst = 1'b1;
        step();
        check_idle("rst_mid");
        rst = 1'b0; start_i = 1'b0;
        step();

        // Reset while in END
        run_div("u50_6", 1'b0, 32'd50, 32'd6, {32'h2, 32'h8}, 1'b0);
        rst = 1'b1;
        step();
        check_idle("rst_end");
        rst = 1'b0; start_i = 1'b0;
        step();

        run_div("s_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'hE}, 1'b0);
        drop_start("s_m100_m7");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 restoring divider for DIV/DIVU, plus its sequencing FSM. It serves as the multi-cycle divide resource for the execute stage.
- The execute stage issues start_i and holds it, along with the operands, for the whole operation. It also asserts its pipeline stall request until ready_o is high.
- annul_i lets the pipeline cancel an in-flight divide, e.g. on a flush.
- The result is packed {remainder, quotient}; the execute stage writes remainder to HI and quotient to LO.

Parameters:
DATA_W, 32, operand width. This is also the iteration count.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  reset, synchronous, active-high
signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU)
opdata1_i  in  DATA_W  dividend
opdata2_i  in  DATA_W  divisor
start_i  in  1  divide request, level; held high by the requester until ready_o is seen
annul_i  in  1  cancel the current operation
result_o  out  2*DATA_W  {remainder, quotient}, valid while ready_o=1
ready_o  out  1  result valid
busy_o  out  1  1 in states ON and DIVZERO

Behaviour:
- Reset:
  - On a sampled rst=1 edge: state=FREE, cnt=0, result_o=0, ready_o=0, busy_o=0.
  - Reset overrides everything, including mid-operation.
- All outputs are registered, except busy_o, which is decoded from state.
- FSM states: FREE, DIVZERO, ON, END.
- FREE:
  - Transition condition: start_i=1 and annul_i=0.
  - If opdata2_i==0, go to DIVZERO.
  - Otherwise latch |a|, |b| and sign info, set cnt=0, and go to ON:
    - |x| is the two's complement magnitude when signed_div_i=1 and x[DATA_W-1]=1; otherwise x is taken as-is.
    - Latch dividend sign sa, divisor sign sb and signed_div_i.
  - Operand inputs are ignored after the latch edge.
- DIVZERO:
  - Next edge: result register = 0, ready_o=1, go to END.
- ON, iterations (cnt != DATA_W):
  - One restoring step per edge on a working register {R[DATA_W:0], Q[DATA_W-1:0]}. R starts at 0; Q starts at |a|.
  - Compute trial = {R[DATA_W-1:0], Q[DATA_W-1]} - {1'b0, |b|}, DATA_W+1 bits.
  - If trial[DATA_W]==0: R=trial, Q={Q[DATA_W-2:0],1}.
  - Else: R={R[DATA_W-1:0],Q[DATA_W-1]}, Q={Q[DATA_W-2:0],0}.
  - cnt++.
- ON, finalize (cnt==DATA_W):
  - Apply sign correction when the latched signed flag is set:
    - Quotient is negated if sa^sb.
    - Remainder is negated if sa (remainder takes the dividend's sign).
  - result_o={rem, quo}, ready_o=1, go to END.
- Latency:
  - Counting the edge that samples start_i as edge 1, ready_o is high after edge DATA_W+2 (34 for DATA_W=32).
  - Divide-by-zero: ready_o is high after edge 2.
- END:
  - ready_o=1 and result_o held while start_i=1.
  - When start_i=0 is sampled: go to FREE, ready_o=0, result_o=0.
  - A back-to-back divide needs at least one cycle with start_i low.
- annul_i:
  - Sampled 1 in DIVZERO, ON or END: go to FREE next edge, ready_o=0, result_o=0, cnt=0. No result is produced.
  - In FREE, annul_i=1 blocks start (annul wins over simultaneous start).
- Overflow case: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0. This falls out of magnitude wrap; no special-casing.
- Width rules:
  - cnt is clog2(DATA_W)+1 bits.
  - Negation is two's complement truncated to DATA_W.

Test Plan:
- Unsigned 100 / 7, start held: ready_o rises after edge 34; result_o = {0x00000002, 0x0000000E}. Drop start_i: ready_o=0 and result_o=0 next edge.
- Signed -7 / 2 (0xFFFFFFF9, 0x00000002): result_o = {0xFFFFFFFF, 0xFFFFFFFD}. The same operands unsigned give {0x00000001, 0x7FFFFFFC}.
- Divisor 0 (dividend 0x12345678): busy_o=1 for one cycle, ready_o after edge 2, result_o = 0.
- annul_i pulsed when cnt==10: state FREE next edge, ready_o stays 0. A new start with 9/3 then returns {0, 3} at edge 34.
- Signed 0x80000000 / 0xFFFFFFFF gives {0x00000000, 0x80000000}. Unsigned 0xFFFFFFFF / 1 gives {0, 0xFFFFFFFF}.
- rst asserted mid-operation (cnt==20), and separately in END: all outputs 0 next edge, FSM in FREE. Operands changed during ON do not affect the result.
